// File: rtl/aemb2_mul_wb_pkg.sv
// ---------------------------------------------------------------------------
// aemb2_mul_wb_pkg
// Shared constants and types for the multiplier writeback tracker.
//   AEMB_RF_AW : register-file address width
//   AEMB_DW    : datapath width
//   AEMB_NTHR  : number of hardware threads (register banks)
//   wb_tag_t   : destination tag {vld, rd, thr} carried beside the multiplier
//   tag_hit()  : read-after-write match of one tag against a decode read
// ---------------------------------------------------------------------------
package aemb2_mul_wb_pkg;

   localparam int AEMB_RF_AW = 5;
   localparam int AEMB_DW    = 32;
   localparam int AEMB_NTHR  = 2;
   localparam int AEMB_TW    = $clog2(AEMB_NTHR);

   typedef struct packed {
      logic                  vld;
      logic [AEMB_RF_AW-1:0] rd;
      logic [AEMB_TW-1:0]    thr;
   } wb_tag_t;

   // A tag blocks decode only if it is live, belongs to the decoding thread,
   // targets a real register (r0 is never written) and matches a used source.
   function automatic logic tag_hit(input wb_tag_t               tag,
                                    input logic [AEMB_TW-1:0]    thr,
                                    input logic [AEMB_RF_AW-1:0] ra,
                                    input logic [AEMB_RF_AW-1:0] rb,
                                    input logic                  ra_use,
                                    input logic                  rb_use);
      return tag.vld && (tag.thr == thr) && (tag.rd != '0) &&
             ((ra_use && (ra == tag.rd)) || (rb_use && (rb == tag.rd)));
   endfunction

endpackage

// File: rtl/aemb2_mul_wb_tag.sv
// ---------------------------------------------------------------------------
// aemb2_tag_pipe
// Depth-DEPTH shift register of writeback tags, advanced by dena in lockstep
// with the multiplier pipeline, with per-stage thread-selective kill.
//   gclk, grst : clock, synchronous active-high reset
//   dena       : advance enable; all stages hold when low
//   kill_x     : flush request, kill_thr selects the thread to flush
//   tag_in     : tag entering stage 1
//   stage      : current contents of stages 1..DEPTH
// The last stage is already committed to the write port and is never killed.
// ENABLE = 0 holds every stage cleared.
// ---------------------------------------------------------------------------
module aemb2_tag_pipe
   import aemb2_mul_wb_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter bit ENABLE = 1'b1
) (
   input  logic                 gclk,
   input  logic                 grst,
   input  logic                 dena,
   input  logic                 kill_x,
   input  logic [AEMB_TW-1:0]   kill_thr,
   input  wb_tag_t              tag_in,
   output wb_tag_t [DEPTH:1]    stage
);

   wb_tag_t [DEPTH:1] stage_reg;
   wb_tag_t [DEPTH:1] stage_next;
   wb_tag_t [DEPTH:1] stage_kill;
   wb_tag_t           tag_in_kill;

   // Kill is applied to the values before they shift, so a killed tag moves
   // on as a bubble rather than surviving one more stage.
   always_comb begin
      stage_kill  = stage_reg;
      tag_in_kill = tag_in;
      for (int k = 1; k < DEPTH; k++) begin
         if (kill_x && (stage_reg[k].thr == kill_thr)) begin
            stage_kill[k].vld = 1'b0;
         end
      end
      if (kill_x && (tag_in.thr == kill_thr)) begin
         tag_in_kill.vld = 1'b0;
      end

      stage_next = stage_kill;
      if (dena) begin
         stage_next[1] = tag_in_kill;
         for (int k = 2; k <= DEPTH; k++) begin
            stage_next[k] = stage_kill[k-1];
         end
      end
   end

   always_ff @(posedge gclk) begin
      if (grst || !ENABLE) begin
         stage_reg <= '0;
      end else begin
         stage_reg <= stage_next;
      end
   end

   assign stage = stage_reg;

endmodule

// File: rtl/aemb2_mul_wb.sv
// ---------------------------------------------------------------------------
// aemb2_mul_wb
// Writeback tracker for the multi-cycle multiplier result path.
//   gclk, grst         : clock, synchronous active-high reset
//   dena               : pipeline advance, shared with the multiplier
//   gpha               : thread of the instruction in OF
//   mul_vld_of, rd_of  : a multiply issues this cycle and its destination
//   kill_x, kill_thr   : thread-selective flush
//   ra_if, rb_if       : decode source indices, qualified by ra_use/rb_use
//   thr_if             : thread of the decoding instruction
//   mul_mx             : multiplier result, aligned with the last tag stage
//   rf_we/rd/thr/dat   : register-file write port
//   hzd                : decode stall while a matching result is in flight
//   busy               : any tag valid
// MUL_LAT (1..4) must equal the multiplier pipeline depth.
// ---------------------------------------------------------------------------
module aemb2_mul_wb
   import aemb2_mul_wb_pkg::*;
#(
   parameter int AEMB_MUL = 1,
   parameter int MUL_LAT  = 2
) (
   input  logic                  gclk,
   input  logic                  grst,
   input  logic                  dena,
   input  logic                  gpha,
   input  logic                  mul_vld_of,
   input  logic [AEMB_RF_AW-1:0] rd_of,
   input  logic                  kill_x,
   input  logic                  kill_thr,
   input  logic [AEMB_RF_AW-1:0] ra_if,
   input  logic [AEMB_RF_AW-1:0] rb_if,
   input  logic                  ra_use,
   input  logic                  rb_use,
   input  logic                  thr_if,
   input  logic [AEMB_DW-1:0]    mul_mx,
   output logic                  rf_we,
   output logic [AEMB_RF_AW-1:0] rf_rd,
   output logic                  rf_thr,
   output logic [AEMB_DW-1:0]    rf_dat,
   output logic                  hzd,
   output logic                  busy
);

   localparam bit MUL_EN = AEMB_MUL[0];

   wb_tag_t              tag_in;
   wb_tag_t [MUL_LAT:1]  stage;
   wb_tag_t              tag_wb;
   logic [MUL_LAT-1:0]   hit;
   logic [MUL_LAT:1]     vld_vec;

   always_comb begin
      tag_in     = '0;
      tag_in.vld = mul_vld_of;
      tag_in.rd  = rd_of;
      tag_in.thr = gpha;
   end

   aemb2_tag_pipe #(
      .DEPTH  (MUL_LAT),
      .ENABLE (MUL_EN)
   ) u_tag_pipe (
      .gclk     (gclk),
      .grst     (grst),
      .dena     (dena),
      .kill_x   (kill_x),
      .kill_thr (kill_thr),
      .tag_in   (tag_in),
      .stage    (stage)
   );

   // The last stage lines up with mul_mx. Gating with dena means a result
   // held across a stall is written once, on the cycle the pipe advances.
   assign tag_wb = stage[MUL_LAT];
   assign rf_we  = MUL_EN & tag_wb.vld & dena & (tag_wb.rd != '0);
   assign rf_rd  = tag_wb.rd;
   assign rf_thr = tag_wb.thr;
   assign rf_dat = mul_mx;

   // Hazard sources: the entering tag and stages 1..MUL_LAT-1. The last stage
   // is left out because the register file forwards the write it is doing.
   assign hit[0] = tag_hit(tag_in, thr_if, ra_if, rb_if, ra_use, rb_use);

   generate
      for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_hzd
         assign hit[gi] = tag_hit(stage[gi], thr_if, ra_if, rb_if, ra_use, rb_use);
      end
      for (genvar gi = 1; gi <= MUL_LAT; gi++) begin : g_busy
         assign vld_vec[gi] = stage[gi].vld;
      end
   endgenerate

   assign hzd  = MUL_EN & (|hit);
   assign busy = |vld_vec;

endmodule

// File: tb/tb_aemb2_mul_wb.sv
module tb_aemb2_mul_wb;

   logic        gclk = 1'b0;
   logic        grst;
   logic        dena;
   logic        gpha;
   logic        mul_vld_of;
   logic [4:0]  rd_of;
   logic        kill_x;
   logic        kill_thr;
   logic [4:0]  ra_if;
   logic [4:0]  rb_if;
   logic        ra_use;
   logic        rb_use;
   logic        thr_if;
   logic [31:0] mul_mx;

   logic        rf_we, rf_thr, hzd, busy;
   logic [4:0]  rf_rd;
   logic [31:0] rf_dat;
   logic        rf_we0, rf_thr0, hzd0, busy0;
   logic [4:0]  rf_rd0;
   logic [31:0] rf_dat0;

   // stand-in two-stage multiplier, advanced by dena like the real one
   logic [31:0] op_a, op_b, p1 = '0, p2 = '0;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   typedef struct { int cyc; logic [4:0] rd; logic thr; logic [31:0] dat; } wr_t;
   typedef struct { int cyc; logic hzd; logic busy; logic chk_rst; } st_t;
   wr_t wq[$];
   st_t sq[$];

   always #5 gclk = ~gclk;

   aemb2_mul_wb #(.AEMB_MUL(1), .MUL_LAT(2)) dut (
      .gclk(gclk), .grst(grst), .dena(dena), .gpha(gpha),
      .mul_vld_of(mul_vld_of), .rd_of(rd_of), .kill_x(kill_x), .kill_thr(kill_thr),
      .ra_if(ra_if), .rb_if(rb_if), .ra_use(ra_use), .rb_use(rb_use),
      .thr_if(thr_if), .mul_mx(mul_mx),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_thr(rf_thr), .rf_dat(rf_dat),
      .hzd(hzd), .busy(busy)
   );

   aemb2_mul_wb #(.AEMB_MUL(0), .MUL_LAT(2)) dut_off (
      .gclk(gclk), .grst(grst), .dena(dena), .gpha(gpha),
      .mul_vld_of(mul_vld_of), .rd_of(rd_of), .kill_x(kill_x), .kill_thr(kill_thr),
      .ra_if(ra_if), .rb_if(rb_if), .ra_use(ra_use), .rb_use(rb_use),
      .thr_if(thr_if), .mul_mx(mul_mx),
      .rf_we(rf_we0), .rf_rd(rf_rd0), .rf_thr(rf_thr0), .rf_dat(rf_dat0),
      .hzd(hzd0), .busy(busy0)
   );

   always @(posedge gclk) begin
      cyc <= cyc + 1;
      if (dena) begin
         p1 <= op_a * op_b;
         p2 <= p1;
      end
   end
   assign mul_mx = p2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
      end
   endtask

   // monitor: writes are popped when the DUT asserts rf_we; status is popped
   // on the cycle it was scheduled for
   always @(negedge gclk) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
         total++; bad++;
         $display("FAIL missing_write cyc=%0d got=none want=rd%0d", wq[0].cyc, wq[0].rd);
         void'(wq.pop_front());
      end
      if (rf_we === 1'b1) begin
         if (wq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write cyc=%0d got=rd%0d thr%0d want=none", cyc, rf_rd, rf_thr);
         end else begin
            wr_t w;
            w = wq.pop_front();
            $display("write cyc=%0d rd=%0d thr=%0d dat=%0d", cyc, rf_rd, rf_thr, rf_dat);
            chk("write_cycle", cyc, w.cyc);
            chk("write_rd", {27'd0, rf_rd}, {27'd0, w.rd});
            chk("write_thr", {31'd0, rf_thr}, {31'd0, w.thr});
            chk("write_dat", rf_dat, w.dat);
         end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
         st_t s;
         s = sq.pop_front();
         if (s.cyc < cyc) begin
            total++; bad++;
            $display("FAIL status_skipped cyc=%0d got=late want=cyc%0d", cyc, s.cyc);
         end else begin
            $display("status cyc=%0d hzd=%0b busy=%0b", cyc, hzd, busy);
            chk("hzd", {31'd0, hzd}, {31'd0, s.hzd});
            chk("busy", {31'd0, busy}, {31'd0, s.busy});
            chk("off_we", {31'd0, rf_we0}, 32'd0);
            chk("off_hzd", {31'd0, hzd0}, 32'd0);
            if (s.chk_rst) begin
               chk("rst_we", {31'd0, rf_we}, 32'd0);
               chk("rst_rd", {27'd0, rf_rd}, 32'd0);
               chk("rst_thr", {31'd0, rf_thr}, 32'd0);
               chk("rst_dat", rf_dat, mul_mx);
            end
         end
      end
   end

   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   task automatic idle();
      mul_vld_of = 0; rd_of = 0; gpha = 0; op_a = 0; op_b = 0;
      kill_x = 0; kill_thr = 0; ra_use = 0; rb_use = 0;
      ra_if = 0; rb_if = 0; thr_if = 0; dena = 1;
   endtask

   task automatic issue(input logic [4:0] rd, input logic thr, input logic [31:0] a, input logic [31:0] b);
      mul_vld_of = 1; rd_of = rd; gpha = thr; op_a = a; op_b = b;
   endtask

   task automatic exp_w(input int c, input logic [4:0] rd, input logic thr, input logic [31:0] dat);
      wr_t w;
      w.cyc = c; w.rd = rd; w.thr = thr; w.dat = dat;
      wq.push_back(w);
   endtask

   task automatic exp_s(input int c, input logic h, input logic b, input logic r);
      st_t s;
      s.cyc = c; s.hzd = h; s.busy = b; s.chk_rst = r;
      sq.push_back(s);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
      $fatal(1);
   end

   initial begin
      int c;
      idle();
      grst = 1;
      repeat (2) tick();
      grst = 0;
      exp_s(cyc, 0, 0, 1);
      tick();

      // single MUL r5 = 7*6, thread 0
      c = cyc;
      issue(5, 0, 7, 6);
      exp_s(c, 0, 0, 0); exp_s(c+1, 0, 1, 0); exp_s(c+2, 0, 1, 0); exp_s(c+3, 0, 0, 0);
      exp_w(c+2, 5, 0, 42);
      tick(); idle(); tick(); tick(); tick();

      // MUL into r0 while decode reads r0
      c = cyc;
      issue(0, 0, 9, 9); ra_use = 1; ra_if = 0; thr_if = 0;
      exp_s(c, 0, 0, 0); exp_s(c+1, 0, 1, 0);
      tick(); mul_vld_of = 0; tick(); idle(); tick(); tick();

      // RAW on r3, same thread
      c = cyc;
      issue(3, 0, 3, 5); ra_use = 1; ra_if = 3; thr_if = 0;
      exp_s(c, 1, 0, 0); exp_s(c+1, 1, 1, 0); exp_s(c+2, 0, 1, 0);
      exp_w(c+2, 3, 0, 15);
      tick(); mul_vld_of = 0; tick(); tick(); idle(); tick();

      // same read from the other thread
      c = cyc;
      issue(3, 0, 2, 2); ra_use = 1; ra_if = 3; thr_if = 1;
      exp_s(c, 0, 0, 0); exp_s(c+1, 0, 1, 0);
      exp_w(c+2, 3, 0, 4);
      tick(); mul_vld_of = 0; tick(); idle(); tick(); tick();

      // RAW through source B, then rb_use dropped
      c = cyc;
      issue(9, 1, 3, 4); rb_use = 1; rb_if = 9; thr_if = 1;
      exp_s(c, 1, 0, 0); exp_s(c+1, 0, 1, 0);
      exp_w(c+2, 9, 1, 12);
      tick(); mul_vld_of = 0; rb_use = 0; tick(); idle(); tick(); tick();

      // dena low for 3 cycles with the tag in T[2]
      c = cyc;
      issue(7, 1, 2, 11);
      exp_s(c, 0, 0, 0); exp_s(c+3, 0, 1, 0); exp_s(c+6, 0, 0, 0);
      exp_w(c+5, 7, 1, 22);
      tick(); mul_vld_of = 0;
      tick(); dena = 0;
      tick(); tick();
      tick(); dena = 1;
      tick(); tick();

      // kill thread 1 in T[1] while thread 0 sits in T[2]
      c = cyc;
      issue(4, 0, 5, 5);
      exp_s(c+2, 0, 1, 0); exp_s(c+3, 0, 0, 0);
      exp_w(c+2, 4, 0, 25);
      tick(); issue(6, 1, 4, 4);
      tick(); mul_vld_of = 0; kill_x = 1; kill_thr = 1;
      tick(); kill_x = 0;
      tick(); tick();

      // kill cannot touch T[2], but does drop the entering tag
      c = cyc;
      issue(8, 0, 3, 3);
      exp_s(c+3, 0, 0, 0);
      exp_w(c+2, 8, 0, 9);
      tick(); idle();
      tick(); kill_x = 1; kill_thr = 0; issue(10, 0, 1, 1);
      tick(); idle();
      tick(); tick();

      // reset with two tags in flight
      c = cyc;
      issue(11, 0, 6, 7);
      tick(); issue(12, 1, 2, 3);
      tick(); mul_vld_of = 0; grst = 1; dena = 0; ra_use = 1; ra_if = 12; thr_if = 1;
      exp_s(c+2, 1, 1, 0); exp_s(c+3, 0, 0, 1);
      tick(); grst = 0; dena = 1;
      tick(); idle();
      tick(); tick(); tick();

      while (wq.size() > 0) begin
         wr_t w;
         w = wq.pop_front();
         total++; bad++;
         $display("FAIL missing_write cyc=%0d got=none want=rd%0d", w.cyc, w.rd);
      end
      while (sq.size() > 0) begin
         st_t s;
         s = sq.pop_front();
         total++; bad++;
         $display("FAIL status_unchecked cyc=%0d got=pending want=checked", s.cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
